// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel servo PWM with clamped, slew-limited pulse-width commands
module servo_pwm_bank #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 12,
  parameter int PERIOD  = 3072,
  parameter int MIN_PW  = 154,
  parameter int MAX_PW  = 307,
  parameter int STOP_PW = 230,
  parameter int STEP    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        ch_en_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [$clog2(NCH):0]  cmd_ch_i,
  input  logic [CNT_W-1:0]      cmd_width_i,
  output logic [NCH-1:0]        pwm_o,
  output logic                  frame_sync_o,
  output logic [NCH-1:0]        settled_o,
  output logic                  cmd_err_o
);
  localparam int CH_W = $clog2(NCH) + 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PW);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PW);
  localparam logic [CNT_W-1:0] STOP_C = CNT_W'(STOP_PW);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [CNT_W:0]   STEP_W = (CNT_W + 1)'(STEP);

  if (MAX_PW >= PERIOD || MIN_PW > MAX_PW) begin : g_bad_cfg
    $error("servo_pwm_bank: pulse-width range must satisfy MIN_PW <= MAX_PW < PERIOD");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d, wc;
  logic [CNT_W-1:0] tgt_q [NCH];
  logic [CNT_W-1:0] tgt_d [NCH];
  logic [CNT_W-1:0] act_q [NCH];
  logic [CNT_W-1:0] act_d [NCH];
  logic [NCH-1:0]   pwm_q, pwm_d, settled_q, settled_d;
  logic [CNT_W:0]   diff, mag;
  logic             fs_q, err_q, err_d, last, accept, ch_ok;

  // Frame counter, command capture and once-per-frame slew of the applied widths
  always_comb begin
    last        = cnt_q == LAST;
    cnt_d       = last ? '0 : cnt_q + 1'b1;
    cmd_ready_o = !reset && !last;
    accept      = cmd_valid_i && cmd_ready_o;
    ch_ok       = cmd_ch_i < CH_W'(NCH);
    wc          = cmd_width_i < MIN_C ? MIN_C : cmd_width_i > MAX_C ? MAX_C : cmd_width_i;
    err_d       = accept && (!ch_ok || wc != cmd_width_i);
    diff        = '0;
    mag         = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_d[i]     = accept && ch_ok && cmd_ch_i == CH_W'(i) ? wc : tgt_q[i];
      diff         = {1'b0, tgt_q[i]} - {1'b0, act_q[i]};
      mag          = diff[CNT_W] ? -diff : diff;
      act_d[i]     = !last ? act_q[i] :
                     (STEP == 0 || mag <= STEP_W) ? tgt_q[i] :
                     diff[CNT_W] ? act_q[i] - STEP_C : act_q[i] + STEP_C;
      pwm_d[i]     = ch_en_i[i] && cnt_q < act_q[i];
      settled_d[i] = act_q[i] == tgt_q[i];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
      pwm_q     <= '0;
      settled_q <= '1;
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i] <= STOP_C;
        act_q[i] <= STOP_C;
      end
    end else begin
      cnt_q     <= cnt_d;
      fs_q      <= last;
      err_q     <= err_d;
      pwm_q     <= pwm_d;
      settled_q <= settled_d;
      tgt_q     <= tgt_d;
      act_q     <= act_d;
    end
  end

  assign pwm_o        = pwm_q;
  assign frame_sync_o = fs_q;
  assign settled_o    = settled_q;
  assign cmd_err_o    = err_q;
endmodule
